crc32_rx_check: RTL and testbench

- GMII receive-side frame checker: the counterpart of the transmit CRC32 generator.
- Detects preamble/SFD and strips the 4-byte FCS from the payload stream.
- Verifies the Ethernet CRC32 over the received frame, checks length and reports per-frame status.
- Sits between the GMII RX pins (registered) and the RX MAC buffer.

---
 rtl/crc32_rx_check.sv | 115 +++++++++++
 tb/tb_crc32_rx_check.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/crc32_rx_check.sv
// GMII receive frame checker: preamble/SFD detect, FCS strip,
// CRC32 residue check, length and PHY error status per frame.
module crc32_rx_check #(
    parameter int          datalen   = 8,
    parameter int          crc_len   = 32,
    parameter logic [31:0] crc       = 32'h04C11DB7,
    parameter int          MIN_FRAME = 64,
    parameter int          MAX_FRAME = 1518
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [datalen-1:0] rx_data,
    input  logic               rx_dv,
    input  logic               rx_er,
    output logic [datalen-1:0] out_data,
    output logic               out_valid,
    output logic               frame_done,
    output logic               fcs_ok,
    output logic               len_err,
    output logic               phy_err,
    output logic [11:0]        frame_len
);

    function automatic logic [crc_len-1:0] reflect(input logic [crc_len-1:0] v);
        logic [crc_len-1:0] r;
        for (int i = 0; i < crc_len; i++) r[i] = v[crc_len-1-i];
        return r;
    endfunction

    localparam logic [crc_len-1:0] POLY_R  = reflect(crc[crc_len-1:0]);
    localparam logic [crc_len-1:0] RESIDUE = 32'hDEBB20E3;
    localparam logic [11:0]        MIN_L   = 12'(MIN_FRAME);
    localparam logic [11:0]        MAX_L   = 12'(MAX_FRAME);
    localparam logic [11:0]        SAT     = 12'hFFF;

    typedef enum logic [1:0] {IDLE, PRE, DATA, DROP} state_t;

    state_t                        state_q;
    logic [crc_len-1:0]            crc_q, crc_d;
    logic [11:0]                   cnt_q, cnt_d;
    logic [3:0][datalen-1:0]       dly_q;
    logic                          phy_q;

    // LSB-first update; reflected poly means no input bit reversal.
    always_comb begin
        crc_d = crc_q;
        for (int i = 0; i < datalen; i++) begin
            crc_d = (crc_d >> 1) ^ ((crc_d[0] ^ rx_data[i]) ? POLY_R : '0);
        end
        cnt_d = (cnt_q == SAT) ? cnt_q : cnt_q + 12'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            crc_q      <= '1;
            cnt_q      <= '0;
            dly_q      <= '0;
            phy_q      <= 1'b0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
            fcs_ok     <= 1'b0;
            len_err    <= 1'b0;
            phy_err    <= 1'b0;
            frame_len  <= '0;
        end else begin
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (rx_dv) state_q <= (rx_data == 8'h55) ? PRE : DROP;
                end
                PRE: begin
                    if (!rx_dv) begin
                        state_q <= IDLE;
                    end else if (rx_data == 8'hD5) begin
                        state_q <= DATA;
                        crc_q   <= '1;
                        cnt_q   <= '0;
                    end else if (rx_data != 8'h55) begin
                        state_q <= DROP;
                    end
                end
                DATA: begin
                    if (rx_dv) begin
                        crc_q <= crc_d;
                        cnt_q <= cnt_d;
                        dly_q <= {dly_q[2:0], rx_data};
                        if (rx_er) phy_q <= 1'b1;
                        // Oldest delay-line byte is payload once 4 bytes are held back.
                        if (cnt_q >= 12'd4) begin
                            out_data  <= dly_q[3];
                            out_valid <= 1'b1;
                        end
                    end else begin
                        frame_done <= 1'b1;
                        fcs_ok     <= (crc_q == RESIDUE);
                        len_err    <= (cnt_q < MIN_L) || (cnt_q > MAX_L);
                        phy_err    <= phy_q;
                        frame_len  <= cnt_q;
                        state_q    <= IDLE;
                        cnt_q      <= '0;
                        phy_q      <= 1'b0;
                    end
                end
                DROP: begin
                    if (!rx_dv) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_crc32_rx_check.sv
// Randomized self-checking bench for crc32_rx_check against
// a frame-level reference model (payload, FCS and status).
module tb_crc32_rx_check;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] rx_data = '0;
    logic       rx_dv = 1'b0;
    logic       rx_er = 1'b0;
    logic [7:0] out_data;
    logic       out_valid, frame_done, fcs_ok, len_err, phy_err;
    logic [11:0] frame_len;

    crc32_rx_check dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_dv(rx_dv),
        .rx_er(rx_er), .out_data(out_data), .out_valid(out_valid),
        .frame_done(frame_done), .fcs_ok(fcs_ok), .len_err(len_err),
        .phy_err(phy_err), .frame_len(frame_len)
    );

    always #5 clk = ~clk;

    typedef byte unsigned bq_t[$];
    typedef struct { bit fcs; bit le; bit pe; int len; } st_t;

    int   tests = 0;
    int   fails = 0;
    bq_t  got_q, exp_q;
    st_t  st_got[$], st_exp[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (out_valid) got_q.push_back(out_data);
            if (frame_done) begin
                st_t s;
                s.fcs = fcs_ok; s.le = len_err; s.pe = phy_err; s.len = int'(frame_len);
                st_got.push_back(s);
            end
        end
    end

    function automatic bit [31:0] crc32(input bq_t d);
        bit [31:0] c = '1;
        foreach (d[i]) begin
            c ^= {24'h0, d[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    function automatic bq_t make_body(input bq_t pay, input bit corrupt);
        bq_t       b = pay;
        bit [31:0] f = crc32(pay);
        if (corrupt) f[$urandom_range(31, 0)] ^= 1'b1;
        for (int i = 0; i < 4; i++) b.push_back(f[8*i +: 8]);
        return b;
    endfunction

    function automatic bq_t rand_pay(input int n);
        bq_t p;
        for (int i = 0; i < n; i++) p.push_back(8'($urandom));
        return p;
    endfunction

    task automatic drive(input byte unsigned b, input bit dv, input bit er);
        @(posedge clk); #1;
        rx_data = b; rx_dv = dv; rx_er = er;
    endtask

    task automatic send(input bq_t body, input int er_idx, input int gap);
        for (int i = 0; i < 7; i++) drive(8'h55, 1'b1, 1'b0);
        drive(8'hD5, 1'b1, 1'b0);
        foreach (body[i]) drive(body[i], 1'b1, i == er_idx);
        for (int i = 0; i < gap; i++) drive(8'h00, 1'b0, 1'b0);
    endtask

    task automatic send_raw(input bq_t w);
        foreach (w[i]) drive(w[i], 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) drive(8'h00, 1'b0, 1'b0);
    endtask

    task automatic expect_frame(input bq_t body, input int er_idx);
        int  n = body.size();
        bq_t pay;
        st_t s;
        for (int i = 0; i < n - 4; i++) pay.push_back(body[i]);
        foreach (pay[i]) exp_q.push_back(pay[i]);
        s.fcs = (n >= 4) &&
                (crc32(pay) == {body[n-1], body[n-2], body[n-3], body[n-4]});
        s.le  = (n < 64) || (n > 1518);
        s.pe  = (er_idx >= 0) && (er_idx < n);
        s.len = (n > 4095) ? 4095 : n;
        st_exp.push_back(s);
    endtask

    task automatic verify(input string tag);
        int bad = 0;
        int m;
        @(negedge clk);
        check({tag, ".nbytes"}, got_q.size(), exp_q.size());
        m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < m; i++) if (got_q[i] != exp_q[i]) bad++;
        check({tag, ".payload_bad"}, bad, 0);
        check({tag, ".ndone"}, st_got.size(), st_exp.size());
        m = (st_got.size() < st_exp.size()) ? st_got.size() : st_exp.size();
        for (int i = 0; i < m; i++) begin
            check($sformatf("%s.fcs%0d", tag, i), st_got[i].fcs, st_exp[i].fcs);
            check($sformatf("%s.len_err%0d", tag, i), st_got[i].le, st_exp[i].le);
            check($sformatf("%s.phy%0d", tag, i), st_got[i].pe, st_exp[i].pe);
            check($sformatf("%s.len%0d", tag, i), st_got[i].len, st_exp[i].len);
        end
        got_q.delete(); exp_q.delete(); st_got.delete(); st_exp.delete();
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".out_valid"}, out_valid, 0);
        check({tag, ".out_data"}, out_data, 0);
        check({tag, ".frame_done"}, frame_done, 0);
        check({tag, ".fcs_ok"}, fcs_ok, 0);
        check({tag, ".len_err"}, len_err, 0);
        check({tag, ".phy_err"}, phy_err, 0);
        check({tag, ".frame_len"}, frame_len, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bq_t nom, bad, p, a, b;
        repeat (3) @(negedge clk);
        check_zero("reset");
        @(posedge clk); #3 rst = 1'b1;

        nom = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                8'h26, 8'h39, 8'hF4, 8'hCB};
        send(nom, -1, 3);
        expect_frame(nom, -1);
        check("nom.model_fcs", st_exp[0].fcs, 1);
        verify("nominal");

        bad = nom;
        bad[12] = 8'hCA;
        send(bad, -1, 3);
        expect_frame(bad, -1);
        verify("badfcs");

        p.delete();
        for (int i = 0; i < 60; i++) p.push_back(8'(i));
        a = make_body(p, 1'b0);
        send(a, -1, 3); expect_frame(a, -1); verify("len64");
        a = make_body(rand_pay(59), 1'b0);
        send(a, -1, 3); expect_frame(a, -1); verify("len63");
        a = make_body(rand_pay(1514), 1'b0);
        send(a, -1, 3); expect_frame(a, -1); verify("len1518");
        a = make_body(rand_pay(1515), 1'b0);
        send(a, -1, 3); expect_frame(a, -1); verify("len1519");

        send_raw('{8'h55, 8'h55, 8'h55});
        verify("abort3");
        send_raw('{8'h5D, 8'h55, 8'h55, 8'hD5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06});
        verify("rej5D");
        send_raw('{8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'hAA,
                   8'h55, 8'hD5, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66});
        verify("rejAA");

        a = make_body(rand_pay(96), 1'b0);
        send(a, 19, 3); expect_frame(a, 19); verify("rxer");

        a = make_body(rand_pay(80), 1'b0);
        for (int i = 0; i < 7; i++) drive(8'h55, 1'b1, 1'b0);
        drive(8'hD5, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) drive(a[i], 1'b1, 1'b0);
        #2 rst = 1'b0;
        #1 check_zero("midreset");
        rx_dv = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        got_q.delete(); st_got.delete();
        a = make_body(rand_pay(70), 1'b0);
        send(a, -1, 3); expect_frame(a, -1); verify("postreset");

        a = make_body(rand_pay(64), 1'b0);
        b = make_body(rand_pay(75), 1'b0);
        send(a, -1, 1); send(b, -1, 3);
        expect_frame(a, -1); expect_frame(b, -1);
        verify("b2b");

        p.delete();
        send(p, -1, 3); expect_frame(p, -1); verify("zero");

        a = make_body(rand_pay(4096), 1'b0);
        send(a, -1, 3); expect_frame(a, -1); verify("sat");

        for (int k = 0; k < 30; k++) begin
            int n  = $urandom_range(120, 0);
            int er = ($urandom_range(7, 0) == 0) ? $urandom_range(n + 3, 0) : -1;
            a = make_body(rand_pay(n), $urandom_range(3, 0) == 0);
            send(a, er, 3); expect_frame(a, er);
            verify($sformatf("rand%0d", k));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
